// File: rtl/bcd_pkg.sv
// Shared BCD constants and the single-digit step function used by every digit slice.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  typedef struct packed {
    logic [3:0] digit;
    logic       carry;
  } bcd_step_t;

  // One increment/decrement of a BCD digit; carry doubles as borrow when counting down.
  function automatic bcd_step_t bcd_step(input logic [3:0] d, input logic up_dn);
    bcd_step_t r;
    if (up_dn) begin
      if (d >= BCD_MAX) begin
        r.digit = BCD_ZERO;
        r.carry = 1'b1;
      end else begin
        r.digit = d + 4'd1;
        r.carry = 1'b0;
      end
    end else begin
      if (d == BCD_ZERO) begin
        r.digit = BCD_MAX;
        r.carry = 1'b1;
      end else begin
        r.digit = (d > BCD_MAX) ? BCD_MAX - 4'd1 : d - 4'd1;
        r.carry = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit with clear/load and a rippled carry/borrow chain.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       en,
  input  logic       up_dn,
  input  logic       carry_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_q, digit_d;
  bcd_step_t  nxt;

  always_comb begin
    nxt       = bcd_step(digit_q, up_dn);
    carry_out = en & carry_in & nxt.carry;
    digit_d   = digit_q;
    if (clr) begin
      digit_d = BCD_ZERO;
    end else if (load) begin
      digit_d = bcd_sat(load_digit);
    end else if (en && carry_in) begin
      digit_d = nxt.digit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter stepped by a free-running prescaler in the clk domain.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int TICK_DIV = 500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   data,
  output logic                  tick,
  output logic                  wrap
);

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          step;
  logic [DIGITS:0] carry_c;

  // A step only happens when neither clr nor load claims the edge.
  always_comb begin
    step    = run && (presc_q == PRESC_LAST) && !clr && !load;
    presc_d = presc_q;
    if (clr || load) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end
    tick_d = step;
    wrap_d = step & carry_c[DIGITS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign carry_c[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .load       (load),
      .load_digit (load_data[4*i +: 4]),
      .en         (step),
      .up_dn      (up_dn),
      .carry_in   (carry_c[i]),
      .digit      (data[4*i +: 4]),
      .carry_out  (carry_c[i+1])
    );
  end

  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter with DIGITS=3, TICK_DIV=4.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        up_dn;
  logic        clr;
  logic        load;
  logic [11:0] load_data;
  logic [11:0] data;
  logic        tick;
  logic        wrap;

  int n_checks = 0;
  int n_errors = 0;

  bcd_updown_counter #(.DIGITS(3), .TICK_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .up_dn     (up_dn),
    .clr       (clr),
    .load      (load),
    .load_data (load_data),
    .data      (data),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Prescaler assumed at 0 with run=1: three quiet cycles, then the step cycle.
  task automatic wait_step(input string tag);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk({tag, "_quiet"}, 32'(tick), 32'd0);
    end
    cyc(1);
    chk({tag, "_tick"}, 32'(tick), 32'd1);
  endtask

  task automatic do_load(input logic [11:0] v);
    run       = 1'b0;
    load      = 1'b1;
    load_data = v;
    cyc(1);
    load      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_data = '0;
    #2;
    chk("rst_data", 32'(data), 32'h000);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    cyc(2);
    rst_n = 1'b1;

    // Free count up for 16 cycles
    for (int c = 1; c <= 16; c++) begin
      cyc(1);
      chk($sformatf("up_tick_c%0d", c), 32'(tick), 32'((c % 4) == 0));
      chk($sformatf("up_data_c%0d", c), 32'(data), 32'(c / 4));
      chk($sformatf("up_wrap_c%0d", c), 32'(wrap), 32'd0);
    end

    // Up wrap from 998
    do_load(12'h998);
    chk("ld998_data", 32'(data), 32'h998);
    chk("ld998_tick", 32'(tick), 32'd0);
    run = 1'b1;
    wait_step("up999");
    chk("up999_data", 32'(data), 32'h999);
    chk("up999_wrap", 32'(wrap), 32'd0);
    wait_step("up000");
    chk("up000_data", 32'(data), 32'h000);
    chk("up000_wrap", 32'(wrap), 32'd1);

    // Down wrap from 000, then direction change mid-interval
    up_dn = 1'b0;
    do_load(12'h000);
    run = 1'b1;
    wait_step("dn999");
    chk("dn999_data", 32'(data), 32'h999);
    chk("dn999_wrap", 32'(wrap), 32'd1);
    wait_step("dn998");
    chk("dn998_data", 32'(data), 32'h998);
    chk("dn998_wrap", 32'(wrap), 32'd0);
    cyc(2);
    up_dn = 1'b1;
    cyc(1);
    chk("dir_quiet", 32'(tick), 32'd0);
    cyc(1);
    chk("dir_tick", 32'(tick), 32'd1);
    chk("dir_data", 32'(data), 32'h999);
    chk("dir_wrap", 32'(wrap), 32'd0);

    // Digit saturation on load, clr beats load
    do_load(12'h1A9);
    chk("sat_1a9", 32'(data), 32'h199);
    do_load(12'hFFF);
    chk("sat_fff", 32'(data), 32'h999);
    clr = 1'b1; load = 1'b1; load_data = 12'h555;
    cyc(1);
    clr = 1'b0; load = 1'b0;
    chk("clr_load_data", 32'(data), 32'h000);
    chk("clr_load_tick", 32'(tick), 32'd0);

    // Middle-digit carry and borrow
    do_load(12'h099);
    run = 1'b1; up_dn = 1'b1;
    wait_step("carry");
    chk("carry_data", 32'(data), 32'h100);
    chk("carry_wrap", 32'(wrap), 32'd0);
    up_dn = 1'b0;
    wait_step("borrow");
    chk("borrow_data", 32'(data), 32'h099);

    // clr mid-interval restarts the prescaler
    do_load(12'h000);
    run = 1'b1; up_dn = 1'b1;
    cyc(2);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_mid_data", 32'(data), 32'h000);
    chk("clr_mid_tick", 32'(tick), 32'd0);
    wait_step("clr_mid");
    chk("clr_mid_step", 32'(data), 32'h001);

    // run=0 holds the prescaler
    cyc(2);
    chk("hold_pre_tick", 32'(tick), 32'd0);
    run = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      chk($sformatf("hold_tick_c%0d", c), 32'(tick), 32'd0);
      chk($sformatf("hold_data_c%0d", c), 32'(data), 32'h001);
    end
    run = 1'b1;
    cyc(1);
    chk("resume_quiet", 32'(tick), 32'd0);
    cyc(1);
    chk("resume_tick", 32'(tick), 32'd1);
    chk("resume_data", 32'(data), 32'h002);

    // Async reset mid-interval
    do_load(12'h057);
    chk("ld057", 32'(data), 32'h057);
    run = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(data), 32'h000);
    chk("arst_tick", 32'(tick), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    wait_step("post_rst");
    chk("post_rst_data", 32'(data), 32'h001);
    chk("post_rst_wrap", 32'(wrap), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
